// File: rtl/gcd_pkg.sv
// gcd_pkg: shared types and defaults for the sequential GCD block.
//   gcd_state_t   - FSM encoding (IDLE / CALC / DONE)
//   GCD_WIDTH_DEF - default operand/result width
package gcd_pkg;

  localparam int GCD_WIDTH_DEF = 8;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } gcd_state_t;

endpackage

// File: rtl/gcd_cmp_sub.sv
// gcd_cmp_sub: combinational compare/subtract datapath for one Euclid step.
//   a, b   - unsigned operands
//   eq     - a == b
//   a_gt_b - a > b
//   diff   - larger minus smaller, so it never underflows
module gcd_cmp_sub #(
  parameter int WIDTH = gcd_pkg::GCD_WIDTH_DEF
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             eq,
  output logic             a_gt_b,
  output logic [WIDTH-1:0] diff
);

  assign eq     = (a == b);
  assign a_gt_b = (a > b);
  assign diff   = a_gt_b ? (a - b) : (b - a);

endmodule

// File: rtl/gcd_seq.sv
// gcd_seq: subtractive-Euclid GCD, one compare/subtract per clock.
//   Clk, Reset          - rising-edge clock, synchronous active-high reset
//   in_valid/in_ready   - operand handshake (ready only in IDLE)
//   X, Y                - unsigned operands
//   out_valid/out_ready - result handshake with backpressure
//   gcd_output          - GCD (0 if either operand was 0)
//   iter_count          - number of subtractions performed
//   zero_in             - at least one operand was zero
module gcd_seq
  import gcd_pkg::*;
#(
  parameter int WIDTH = GCD_WIDTH_DEF
) (
  input  logic             Clk,
  input  logic             Reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] X,
  input  logic [WIDTH-1:0] Y,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] gcd_output,
  output logic [WIDTH-1:0] iter_count,
  output logic             zero_in
);

  gcd_state_t       state;
  logic [WIDTH-1:0] xreg, yreg, cnt;
  logic             eq, a_gt_b;
  logic [WIDTH-1:0] diff;

  gcd_cmp_sub #(.WIDTH(WIDTH)) u_cmp (
    .a      (xreg),
    .b      (yreg),
    .eq     (eq),
    .a_gt_b (a_gt_b),
    .diff   (diff)
  );

  // Handshake flags decode straight from the state register, so they are
  // registered and mutually exclusive by construction.
  assign in_ready  = (state == IDLE);
  assign out_valid = (state == DONE);

  always_ff @(posedge Clk) begin
    if (Reset) begin
      state      <= IDLE;
      xreg       <= '0;
      yreg       <= '0;
      cnt        <= '0;
      gcd_output <= '0;
      iter_count <= '0;
      zero_in    <= 1'b0;
    end else begin
      case (state)
        IDLE: if (in_valid) begin
          xreg <= X;
          yreg <= Y;
          cnt  <= '0;
          // A zero operand would never converge by subtraction; report it
          // directly and skip CALC.
          if (X == '0 || Y == '0) begin
            gcd_output <= '0;
            iter_count <= '0;
            zero_in    <= 1'b1;
            state      <= DONE;
          end else begin
            zero_in <= 1'b0;
            state   <= CALC;
          end
        end
        CALC: begin
          if (eq) begin
            gcd_output <= xreg;
            iter_count <= cnt;
            state      <= DONE;
          end else begin
            // Always reduce the larger operand; cnt cannot exceed 2^W-2.
            if (a_gt_b) xreg <= diff;
            else        yreg <= diff;
            cnt <= cnt + 1'b1;
          end
        end
        DONE: if (out_ready) state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_gcd_seq.sv
module tb_gcd_seq;

  logic        Clk = 1'b0;
  logic        Reset;

  logic        in_valid8, in_ready8, out_valid8, out_ready8, zero_in8;
  logic [7:0]  X8, Y8, gcd8, iter8;

  logic        in_valid16, in_ready16, out_valid16, out_ready16, zero_in16;
  logic [15:0] X16, Y16, gcd16, iter16;

  int passed = 0;
  int total  = 0;

  always #5 Clk = ~Clk;

  gcd_seq #(.WIDTH(8)) dut8 (
    .Clk(Clk), .Reset(Reset),
    .in_valid(in_valid8), .in_ready(in_ready8), .X(X8), .Y(Y8),
    .out_valid(out_valid8), .out_ready(out_ready8),
    .gcd_output(gcd8), .iter_count(iter8), .zero_in(zero_in8)
  );

  gcd_seq #(.WIDTH(16)) dut16 (
    .Clk(Clk), .Reset(Reset),
    .in_valid(in_valid16), .in_ready(in_ready16), .X(X16), .Y(Y16),
    .out_valid(out_valid16), .out_ready(out_ready16),
    .gcd_output(gcd16), .iter_count(iter16), .zero_in(zero_in16)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
  endtask

  // Accept one operand pair on dut8 and count edges until out_valid,
  // the accept edge being edge 1. out_ready8 is held high.
  task automatic run8(input string tag, input logic [7:0] x, input logic [7:0] y,
                      input int eg, input int ei, input int ez, input int eedges);
    int edges;
    @(negedge Clk);
    in_valid8 = 1'b1; X8 = x; Y8 = y;
    @(posedge Clk); #1;
    in_valid8 = 1'b0;
    edges = 1;
    while (!out_valid8 && edges < 1000) begin
      @(posedge Clk); #1;
      edges++;
    end
    chk({tag, "_edges"}, edges, eedges);
    chk({tag, "_gcd"},   gcd8, eg);
    chk({tag, "_iter"},  iter8, ei);
    chk({tag, "_zero"},  zero_in8, ez);
    chk({tag, "_exclusive"}, in_ready8, 0);
    @(posedge Clk); #1;
    chk({tag, "_idle_again"}, {out_valid8, in_ready8}, 2'b01);
  endtask

  initial begin
    int edges;
    Reset = 1'b1;
    in_valid8 = 0; X8 = 0; Y8 = 0; out_ready8 = 1;
    in_valid16 = 0; X16 = 0; Y16 = 0; out_ready16 = 0;
    repeat (2) @(posedge Clk);
    #1;
    chk("rst_in_ready", in_ready8, 1);
    chk("rst_out_valid", out_valid8, 0);
    chk("rst_gcd", gcd8, 0);
    chk("rst_iter", iter8, 0);
    chk("rst_zero", zero_in8, 0);
    chk("rst16_in_ready", in_ready16, 1);
    @(negedge Clk); Reset = 1'b0;

    run8("g48_18", 8'd48, 8'd18, 6, 4, 0, 6);
    run8("g0_5",   8'd0,  8'd5,  0, 0, 1, 1);
    run8("g7_7",   8'd7,  8'd7,  7, 0, 0, 2);
    run8("g255_1", 8'd255, 8'd1, 1, 254, 0, 256);
    run8("g9_0",   8'd9,  8'd0,  0, 0, 1, 1);

    // Backpressure on the 16-bit instance.
    @(negedge Clk);
    in_valid16 = 1'b1; X16 = 16'd1000; Y16 = 16'd600;
    @(posedge Clk); #1;
    in_valid16 = 1'b0;
    edges = 1;
    while (!out_valid16 && edges < 100) begin
      @(posedge Clk); #1;
      edges++;
    end
    chk("bp_edges", edges, 5);
    for (int i = 0; i < 3; i++) begin
      @(negedge Clk);
      in_valid16 = 1'b1; X16 = 16'd30; Y16 = 16'd20;
      @(posedge Clk); #1;
      in_valid16 = 1'b0;
      chk("bp_hold_valid", out_valid16, 1);
      chk("bp_hold_ready", in_ready16, 0);
      chk("bp_hold_gcd",   gcd16, 200);
      chk("bp_hold_iter",  iter16, 3);
    end
    @(negedge Clk); out_ready16 = 1'b1;
    @(posedge Clk); #1;
    chk("bp_release_ready", in_ready16, 1);
    chk("bp_release_valid", out_valid16, 0);
    chk("bp_keep_gcd", gcd16, 200);
    @(negedge Clk); out_ready16 = 1'b0;

    // Reset mid-CALC aborts the operation.
    @(negedge Clk);
    in_valid8 = 1'b1; X8 = 8'd200; Y8 = 8'd3;
    @(posedge Clk); #1;
    in_valid8 = 1'b0;
    repeat (3) @(posedge Clk);
    #1;
    chk("mid_calc_busy", {out_valid8, in_ready8}, 2'b00);
    @(negedge Clk); Reset = 1'b1;
    @(posedge Clk); #1;
    chk("abort_in_ready", in_ready8, 1);
    chk("abort_out_valid", out_valid8, 0);
    chk("abort_gcd", gcd8, 0);
    chk("abort_iter", iter8, 0);
    @(negedge Clk); Reset = 1'b0;
    run8("g12_8", 8'd12, 8'd8, 4, 2, 0, 4);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
